// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multicycle MIPS control FSM driving ALU function, datapath muxes and memory handshake.
module mips_multicycle_control (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       flag_z_i,
  input  logic       mem_ready_i,
  output logic [4:0] alu_fn_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       iord_o,
  output logic       halt_o
);
  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, RTYPE_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP, ERROR
  } state_e;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [4:0] FN_ADD = 5'b00001, FN_SUB = 5'b10001;
  state_e state_q, state_d;
  logic [4:0] r_fn;
  logic       r_ok, r_shift;
  always_comb begin
    r_fn = 5'b00000;
    r_ok = 1'b1;
    case (funct_i)
      6'h20: r_fn = 5'b00001;
      6'h22: r_fn = 5'b10001;
      6'h24: r_fn = 5'b00000;
      6'h25: r_fn = 5'b00100;
      6'h26: r_fn = 5'b01000;
      6'h27: r_fn = 5'b01100;
      6'h2A: r_fn = 5'b10011;
      6'h2B: r_fn = 5'b10111;
      6'h00: r_fn = 5'b00010;
      6'h02: r_fn = 5'b01010;
      6'h03: r_fn = 5'b01110;
      default: r_ok = 1'b0;
    endcase
  end
  assign r_shift = (funct_i == 6'h00) || (funct_i == 6'h02) || (funct_i == 6'h03);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= INIT;
    else         state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:     state_d = FETCH;
      FETCH:    state_d = mem_ready_i ? DECODE : FETCH;
      DECODE:
        case (opcode_i)
          OP_LW, OP_SW:    state_d = MEMADR;
          OP_R:            state_d = r_ok ? RTYPE_EX : ERROR;
          OP_ADDI:         state_d = ADDI_EX;
          OP_BEQ, OP_BNE:  state_d = BRANCH;
          OP_J:            state_d = JUMP;
          default:         state_d = ERROR;
        endcase
      MEMADR:   state_d = (opcode_i == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    state_d = mem_ready_i ? MEMWB : MEMRD;
      MEMWR:    state_d = mem_ready_i ? FETCH : MEMWR;
      RTYPE_EX: state_d = RTYPE_WB;
      ADDI_EX:  state_d = ADDI_WB;
      MEMWB, RTYPE_WB, ADDI_WB, BRANCH, JUMP: state_d = FETCH;
      default:  state_d = ERROR;
    endcase
  end
  always_comb begin
    alu_fn_o = 5'b0; alu_src_a_o = 2'b00; alu_src_b_o = 2'b00;
    pc_write_o = 1'b0; pc_src_o = 2'b00; ir_write_o = 1'b0;
    mem_read_o = 1'b0; mem_write_o = 1'b0; reg_write_o = 1'b0;
    reg_dst_o = 1'b0; mem_to_reg_o = 1'b0; iord_o = 1'b0; halt_o = 1'b0;
    case (state_q)
      FETCH: begin
        alu_fn_o = FN_ADD; alu_src_b_o = 2'b01; mem_read_o = 1'b1;
        ir_write_o = mem_ready_i; pc_write_o = mem_ready_i;
      end
      DECODE:  begin alu_fn_o = FN_ADD; alu_src_b_o = 2'b11; end
      MEMADR, ADDI_EX: begin alu_fn_o = FN_ADD; alu_src_a_o = 2'b01; alu_src_b_o = 2'b10; end
      MEMRD:   begin iord_o = 1'b1; mem_read_o = 1'b1; end
      MEMWB:   begin reg_write_o = 1'b1; mem_to_reg_o = 1'b1; end
      MEMWR:   begin iord_o = 1'b1; mem_write_o = 1'b1; end
      RTYPE_EX: begin alu_fn_o = r_fn; alu_src_a_o = r_shift ? 2'b10 : 2'b01; end
      RTYPE_WB: begin reg_write_o = 1'b1; reg_dst_o = 1'b1; end
      ADDI_WB: reg_write_o = 1'b1;
      BRANCH: begin
        alu_fn_o = FN_SUB; alu_src_a_o = 2'b01; pc_src_o = 2'b01;
        pc_write_o = (opcode_i == OP_BNE) ? ~flag_z_i : flag_z_i;
      end
      JUMP:    begin pc_write_o = 1'b1; pc_src_o = 2'b10; end
      ERROR:   halt_o = 1'b1;
      default: ;
    endcase
  end
endmodule
